ram_mfc_controller: RTL and testbench

Byte-addressed 512-byte main memory with the MFA/MFC handshake used by the control unit for instruction fetch, load and store. Sits directly downstream of the control unit and datapath: the control unit raises MFA with RW, data size and address (from MAR or the trap vector), and waits for MFC before latching IR or MDR. Models a fixed, parameterised access latency so the control unit's MFC wait states are exercised.

---
 rtl/mem_pkg.sv | 35 +++
 rtl/ram_mfc_controller_if.sv | 32 +++
 rtl/ram_byte_array.sv | 44 ++++
 rtl/ram_mfc_controller.sv | 160 ++++++++++++++++
 tb/tb_ram_mfc_controller.sv | 186 ++++++++++++++++++
 5 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the main-memory controller and its users.
// Holds the access-size encodings, the controller state type, the memory
// geometry, the trap vector address used by the control unit, and the
// alignment-check helper.
package mem_pkg;

   localparam logic [1:0] SIZE_BYTE = 2'b00;
   localparam logic [1:0] SIZE_HALF = 2'b01;
   localparam logic [1:0] SIZE_WORD = 2'b11;

   localparam int unsigned MEM_BYTES   = 32'd512;
   localparam logic [8:0]  TRAP_VECTOR = 9'd448;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      WAIT = 2'b01,
      DONE = 2'b10
   } state_t;

   // A halfword needs an even address, a word a multiple of four;
   // the reserved size encoding is always treated as an error.
   function automatic logic is_misaligned(input logic [1:0] size,
                                          input logic [1:0] addr_lo);
      logic bad;
      bad = 1'b0;
      case (size)
         SIZE_BYTE: bad = 1'b0;
         SIZE_HALF: bad = addr_lo[0];
         SIZE_WORD: bad = (addr_lo != 2'b00);
         default:   bad = 1'b1;
      endcase
      return bad;
   endfunction

endpackage

// File: rtl/ram_mfc_controller_if.sv
// MFA/MFC memory bus between the control unit (master) and the memory
// controller (slave).
//   ramMFA       request, held high until MFC is seen
//   ramRW        0 = read, 1 = write
//   ramDataSize  00 byte, 01 half, 11 word, 10 reserved
//   ramAddress   byte address
//   dataIn       right-justified write data
//   dataOut      right-justified, zero-extended read data
//   ramMFC       access complete
//   misaligned   error flag, valid while ramMFC is high
interface ram_mfc_controller_if;

   logic        ramMFA;
   logic        ramRW;
   logic [1:0]  ramDataSize;
   logic [8:0]  ramAddress;
   logic [31:0] dataIn;
   logic [31:0] dataOut;
   logic        ramMFC;
   logic        misaligned;

   modport master (
      output ramMFA, ramRW, ramDataSize, ramAddress, dataIn,
      input  dataOut, ramMFC, misaligned
   );

   modport slave (
      input  ramMFA, ramRW, ramDataSize, ramAddress, dataIn,
      output dataOut, ramMFC, misaligned
   );

endinterface

// File: rtl/ram_byte_array.sv
// 512 x 8 byte storage with four byte-lane write enables.
// Lane i addresses mem[base + i]; lane 0 carries wdata[31:24] (big-endian
// most significant byte) and lane 3 carries wdata[7:0]. The 4-byte read
// at base is combinational. Storage has no reset so contents survive a
// controller reset.
//   clk      write clock
//   base     byte address of lane 0
//   lane_we  per-lane write enable, bit i -> mem[base + i]
//   wdata    write data, lane 0 in [31:24]
//   rdata    {mem[base], mem[base+1], mem[base+2], mem[base+3]}
module ram_byte_array
   import mem_pkg::*;
(
   input  logic        clk,
   input  logic [8:0]  base,
   input  logic [3:0]  lane_we,
   input  logic [31:0] wdata,
   output logic [31:0] rdata
);

   logic [7:0] mem_r [MEM_BYTES];
   logic [8:0] addr1_s;
   logic [8:0] addr2_s;
   logic [8:0] addr3_s;

   // Lane addresses; they only wrap for reads that the caller discards.
   always_comb begin
      addr1_s = base + 9'd1;
      addr2_s = base + 9'd2;
      addr3_s = base + 9'd3;
   end

   // Byte-lane writes.
   always_ff @(posedge clk) begin
      if (lane_we[0]) mem_r[base]    <= wdata[31:24];
      if (lane_we[1]) mem_r[addr1_s] <= wdata[23:16];
      if (lane_we[2]) mem_r[addr2_s] <= wdata[15:8];
      if (lane_we[3]) mem_r[addr3_s] <= wdata[7:0];
   end

   // Combinational 4-byte read.
   assign rdata = {mem_r[base], mem_r[addr1_s], mem_r[addr2_s], mem_r[addr3_s]};

endmodule

// File: rtl/ram_mfc_controller.sv
// Byte-addressed 512-byte main memory behind the MFA/MFC handshake.
// A request is latched in IDLE, held for WAIT_CYCLES+1 edges in WAIT
// (abortable by dropping MFA), then performed on the DONE-entry edge.
// MFC stays high until MFA drops.
//   Clk    system clock, rising edge
//   reset  asynchronous active-low reset; memory contents are kept
//   bus    slave side of ram_mfc_controller_if
module ram_mfc_controller
   import mem_pkg::*;
#(
   parameter int unsigned WAIT_CYCLES = 32'd2
)
(
   input  logic                  Clk,
   input  logic                  reset,
   ram_mfc_controller_if.slave   bus
);

   localparam int unsigned CNT_W    = (WAIT_CYCLES < 32'd2) ? 32'd1 : $clog2(WAIT_CYCLES + 32'd1);
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(32'd1);
   localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(32'd0);

   state_t            state_r;
   logic [CNT_W-1:0]  cnt_r;
   logic              rw_r;
   logic [1:0]        size_r;
   logic [8:0]        addr_r;
   logic [31:0]       din_r;
   logic [31:0]       data_out_r;
   logic              mfc_r;
   logic              misaligned_r;

   logic              access_s;
   logic              bad_s;
   logic [3:0]        lane_mask_s;
   logic [3:0]        lane_we_s;
   logic [31:0]       wdata_s;
   logic [31:0]       rdata_s;
   logic [31:0]       rd_steered_s;

   ram_byte_array u_array (
      .clk     (Clk),
      .base    (addr_r),
      .lane_we (lane_we_s),
      .wdata   (wdata_s),
      .rdata   (rdata_s)
   );

   // The access happens on the WAIT edge that sees the counter expired
   // with MFA still high; that edge is also the DONE-entry edge.
   always_comb begin
      access_s = (state_r == WAIT) && bus.ramMFA && (cnt_r == CNT_ZERO);
      bad_s    = is_misaligned(size_r, addr_r[1:0]);
   end

   // Lane steering between right-justified bus data and big-endian storage.
   always_comb begin
      lane_mask_s  = 4'b0000;
      wdata_s      = 32'h0000_0000;
      rd_steered_s = 32'h0000_0000;
      case (size_r)
         SIZE_BYTE: begin
            lane_mask_s  = 4'b0001;
            wdata_s      = {din_r[7:0], 24'h00_0000};
            rd_steered_s = {24'h00_0000, rdata_s[31:24]};
         end
         SIZE_HALF: begin
            lane_mask_s  = 4'b0011;
            wdata_s      = {din_r[15:0], 16'h0000};
            rd_steered_s = {16'h0000, rdata_s[31:16]};
         end
         SIZE_WORD: begin
            lane_mask_s  = 4'b1111;
            wdata_s      = din_r;
            rd_steered_s = rdata_s;
         end
         default: begin
            lane_mask_s  = 4'b0000;
            wdata_s      = 32'h0000_0000;
            rd_steered_s = 32'h0000_0000;
         end
      endcase
      if (access_s && rw_r && !bad_s) begin
         lane_we_s = lane_mask_s;
      end else begin
         lane_we_s = 4'b0000;
      end
   end

   // Handshake FSM with registered MFC, misaligned and read data.
   always_ff @(posedge Clk or negedge reset) begin
      if (!reset) begin
         state_r      <= IDLE;
         cnt_r        <= CNT_ZERO;
         rw_r         <= 1'b0;
         size_r       <= SIZE_BYTE;
         addr_r       <= 9'd0;
         din_r        <= 32'h0000_0000;
         data_out_r   <= 32'h0000_0000;
         mfc_r        <= 1'b0;
         misaligned_r <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               if (bus.ramMFA) begin
                  rw_r    <= bus.ramRW;
                  size_r  <= bus.ramDataSize;
                  addr_r  <= bus.ramAddress;
                  din_r   <= bus.dataIn;
                  cnt_r   <= CNT_LOAD;
                  state_r <= WAIT;
               end else begin
                  state_r <= IDLE;
               end
            end
            WAIT: begin
               if (!bus.ramMFA) begin
                  // Abort: nothing written, MFC never raised.
                  cnt_r   <= CNT_ZERO;
                  state_r <= IDLE;
               end else if (cnt_r == CNT_ZERO) begin
                  state_r      <= DONE;
                  mfc_r        <= 1'b1;
                  misaligned_r <= bad_s;
                  if (bad_s) begin
                     data_out_r <= 32'h0000_0000;
                  end else if (!rw_r) begin
                     data_out_r <= rd_steered_s;
                  end else begin
                     data_out_r <= data_out_r;
                  end
               end else begin
                  cnt_r <= cnt_r - CNT_ONE;
               end
            end
            DONE: begin
               if (!bus.ramMFA) begin
                  state_r      <= IDLE;
                  mfc_r        <= 1'b0;
                  misaligned_r <= 1'b0;
               end else begin
                  state_r <= DONE;
               end
            end
            default: begin
               state_r      <= IDLE;
               cnt_r        <= CNT_ZERO;
               mfc_r        <= 1'b0;
               misaligned_r <= 1'b0;
            end
         endcase
      end
   end

   assign bus.dataOut    = data_out_r;
   assign bus.ramMFC     = mfc_r;
   assign bus.misaligned = misaligned_r;

endmodule

// File: tb/tb_ram_mfc_controller.sv
// Directed bench for ram_mfc_controller: one instance with WAIT_CYCLES = 2
// and one with WAIT_CYCLES = 0, sharing clock and reset.
module tb_ram_mfc_controller;
   import mem_pkg::*;

   logic Clk;
   logic reset;
   int   checks;
   int   errors;

   ram_mfc_controller_if bus2 ();
   ram_mfc_controller_if bus0 ();

   ram_mfc_controller #(.WAIT_CYCLES(32'd2)) dut2 (.Clk(Clk), .reset(reset), .bus(bus2));
   ram_mfc_controller #(.WAIT_CYCLES(32'd0)) dut0 (.Clk(Clk), .reset(reset), .bus(bus0));

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   function automatic logic get_mfc(input bit sel);
      return sel ? bus0.ramMFC : bus2.ramMFC;
   endfunction

   function automatic logic [31:0] get_dout(input bit sel);
      return sel ? bus0.dataOut : bus2.dataOut;
   endfunction

   function automatic logic get_mis(input bit sel);
      return sel ? bus0.misaligned : bus2.misaligned;
   endfunction

   task automatic drive(input bit sel, input logic mfa, input logic rw, input logic [1:0] sz,
                        input logic [8:0] a, input logic [31:0] d);
      if (sel) begin
         bus0.ramMFA = mfa; bus0.ramRW = rw; bus0.ramDataSize = sz;
         bus0.ramAddress = a; bus0.dataIn = d;
      end else begin
         bus2.ramMFA = mfa; bus2.ramRW = rw; bus2.ramDataSize = sz;
         bus2.ramAddress = a; bus2.dataIn = d;
      end
   endtask

   // Full request: checks MFC latency and that MFC falls one edge after MFA drops.
   task automatic req(input bit sel, input logic rw, input logic [1:0] sz, input logic [8:0] a,
                      input logic [31:0] d, input string tag,
                      output logic [31:0] q, output logic mis);
      int n;
      @(negedge Clk);
      drive(sel, 1'b1, rw, sz, a, d);
      n = 0;
      do begin
         @(negedge Clk);
         n++;
      end while (!get_mfc(sel) && n < 20);
      check({tag, " latency"}, 32'(n), sel ? 32'd2 : 32'd4);
      q   = get_dout(sel);
      mis = get_mis(sel);
      drive(sel, 1'b0, rw, sz, a, d);
      @(negedge Clk);
      check({tag, " mfc drop"}, {31'd0, get_mfc(sel)}, 32'd0);
   endtask

   logic [31:0] q;
   logic        mis;

   initial begin
      checks = 0;
      errors = 0;
      reset  = 1'b0;
      drive(1'b0, 1'b0, 1'b0, SIZE_WORD, 9'd0, 32'h0);
      drive(1'b1, 1'b0, 1'b0, SIZE_WORD, 9'd0, 32'h0);
      #1;
      check("reset mfc", {31'd0, bus2.ramMFC}, 32'd0);
      check("reset mis", {31'd0, bus2.misaligned}, 32'd0);
      check("reset dout", bus2.dataOut, 32'h0);
      check("reset dout w0", bus0.dataOut, 32'h0);
      @(negedge Clk);
      @(negedge Clk);
      reset = 1'b1;

      // Preload through the bus.
      req(1'b0, 1'b1, SIZE_WORD, 9'd0, 32'h8C22_0004, "wr w0", q, mis);
      check("wr w0 dout kept", q, 32'h0);
      check("wr w0 mis", {31'd0, mis}, 32'd0);
      req(1'b0, 1'b1, SIZE_WORD, 9'd4, 32'h0000_0000, "wr w4", q, mis);
      req(1'b0, 1'b1, SIZE_WORD, TRAP_VECTOR, 32'h0C00_0070, "wr trap", q, mis);

      req(1'b0, 1'b0, SIZE_WORD, 9'd0, 32'h0, "rd w0", q, mis);
      check("rd w0 data", q, 32'h8C22_0004);
      check("rd w0 mis", {31'd0, mis}, 32'd0);

      // Byte and halfword lane writes.
      req(1'b0, 1'b1, SIZE_BYTE, 9'd5, 32'hFFFF_FFAB, "wr b5", q, mis);
      check("wr b5 dout kept", q, 32'h8C22_0004);
      req(1'b0, 1'b0, SIZE_WORD, 9'd4, 32'h0, "rd w4 a", q, mis);
      check("rd w4 a data", q, 32'h00AB_0000);
      req(1'b0, 1'b1, SIZE_HALF, 9'd6, 32'hEEEE_1234, "wr h6", q, mis);
      req(1'b0, 1'b0, SIZE_WORD, 9'd4, 32'h0, "rd w4 b", q, mis);
      check("rd w4 b data", q, 32'h00AB_1234);
      req(1'b0, 1'b0, SIZE_BYTE, 9'd5, 32'h0, "rd b5", q, mis);
      check("rd b5 data", q, 32'h0000_00AB);
      req(1'b0, 1'b0, SIZE_HALF, 9'd0, 32'h0, "rd h0", q, mis);
      check("rd h0 data", q, 32'h0000_8C22);

      // Misaligned and reserved accesses.
      req(1'b0, 1'b0, SIZE_HALF, 9'd3, 32'h0, "rd h3", q, mis);
      check("rd h3 mis", {31'd0, mis}, 32'd1);
      check("rd h3 data", q, 32'h0);
      req(1'b0, 1'b0, SIZE_WORD, 9'd4, 32'h0, "rd w4 c", q, mis);
      req(1'b0, 1'b1, SIZE_WORD, 9'd2, 32'hFFFF_FFFF, "wr w2", q, mis);
      check("wr w2 mis", {31'd0, mis}, 32'd1);
      check("wr w2 data", q, 32'h0);
      req(1'b0, 1'b0, 2'b10, 9'd0, 32'h0, "rd rsv", q, mis);
      check("rd rsv mis", {31'd0, mis}, 32'd1);
      check("rd rsv data", q, 32'h0);
      req(1'b0, 1'b0, SIZE_WORD, 9'd0, 32'h0, "rd w0 b", q, mis);
      check("rd w0 b data", q, 32'h8C22_0004);
      req(1'b0, 1'b0, SIZE_WORD, 9'd4, 32'h0, "rd w4 d", q, mis);
      check("rd w4 d data", q, 32'h00AB_1234);

      // Abort a write after one WAIT edge.
      @(negedge Clk);
      drive(1'b0, 1'b1, 1'b1, SIZE_WORD, 9'd0, 32'hDEAD_BEEF);
      @(negedge Clk);
      @(negedge Clk);
      check("abort mfc a", {31'd0, bus2.ramMFC}, 32'd0);
      drive(1'b0, 1'b0, 1'b1, SIZE_WORD, 9'd0, 32'hDEAD_BEEF);
      for (int i = 0; i < 3; i++) begin
         @(negedge Clk);
         check("abort mfc b", {31'd0, bus2.ramMFC}, 32'd0);
      end
      req(1'b0, 1'b0, SIZE_WORD, 9'd0, 32'h0, "rd after abort", q, mis);
      check("rd after abort data", q, 32'h8C22_0004);

      // Reset during WAIT of a write.
      @(negedge Clk);
      drive(1'b0, 1'b1, 1'b1, SIZE_WORD, 9'd4, 32'hCAFE_F00D);
      @(negedge Clk);
      @(negedge Clk);
      reset = 1'b0;
      #1;
      check("rst wait mfc", {31'd0, bus2.ramMFC}, 32'd0);
      check("rst wait dout", bus2.dataOut, 32'h0);
      drive(1'b0, 1'b0, 1'b0, SIZE_WORD, 9'd0, 32'h0);
      @(negedge Clk);
      reset = 1'b1;
      req(1'b0, 1'b0, SIZE_WORD, 9'd4, 32'h0, "rd w4 rst", q, mis);
      check("rd w4 rst data", q, 32'h00AB_1234);
      req(1'b0, 1'b0, SIZE_WORD, TRAP_VECTOR, 32'h0, "rd trap", q, mis);
      check("rd trap data", q, 32'h0C00_0070);

      // Zero wait cycles, and MFA held high after completion.
      req(1'b1, 1'b1, SIZE_WORD, 9'd16, 32'h0A0B_0C0D, "w0 wr", q, mis);
      @(negedge Clk);
      drive(1'b1, 1'b1, 1'b0, SIZE_WORD, 9'd16, 32'h0);
      @(negedge Clk);
      check("w0 hold lat", {31'd0, bus0.ramMFC}, 32'd0);
      @(negedge Clk);
      check("w0 hold mfc", {31'd0, bus0.ramMFC}, 32'd1);
      check("w0 hold data", bus0.dataOut, 32'h0A0B_0C0D);
      // Inputs change to a write while held; it must be ignored.
      drive(1'b1, 1'b1, 1'b1, SIZE_WORD, 9'd16, 32'hFFFF_FFFF);
      for (int i = 0; i < 5; i++) begin
         @(negedge Clk);
         check("w0 held mfc", {31'd0, bus0.ramMFC}, 32'd1);
         check("w0 held data", bus0.dataOut, 32'h0A0B_0C0D);
      end
      drive(1'b1, 1'b0, 1'b0, SIZE_WORD, 9'd16, 32'h0);
      @(negedge Clk);
      check("w0 drop mfc", {31'd0, bus0.ramMFC}, 32'd0);
      req(1'b1, 1'b0, SIZE_WORD, 9'd16, 32'h0, "w0 rd", q, mis);
      check("w0 rd data", q, 32'h0A0B_0C0D);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
